// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between two requesters and the
// ALU arbiter. Each per-port field is packed with port 0 in the low slice.
//   req_valid/req_ready : per-port request handshake
//   req_op/form/vec/sel : per-port operation descriptor (3/1/2/4 bits)
//   req_opnd            : per-port {A,B,C,D}, A in the top word of the slice
//   rsp_valid/rsp_ready : per-port response handshake
//   rsp_Y1/rsp_Y2       : per-port results
//   rsp_err             : per-port "opcode unsupported" flag
// modport master = requester side, modport slave = arbiter side.
interface alu_arbiter_if #(
    parameter int DATA_W = 32
) ();
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [5:0]          req_op;
    logic [1:0]          req_form;
    logic [3:0]          req_vec;
    logic [7:0]          req_sel;
    logic [8*DATA_W-1:0] req_opnd;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [2*DATA_W-1:0] rsp_Y1;
    logic [2*DATA_W-1:0] rsp_Y2;
    logic [1:0]          rsp_err;

    modport master (
        output req_valid, req_op, req_form, req_vec, req_sel, req_opnd, rsp_ready,
        input  req_ready, rsp_valid, rsp_Y1, rsp_Y2, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_form, req_vec, req_sel, req_opnd, rsp_ready,
        output req_ready, rsp_valid, rsp_Y1, rsp_Y2, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port arbiter and issue controller for the shared
// combinational ALU. One request is granted per cycle, registered into an
// issue stage that drives the ALU, and the ALU results are captured one
// cycle later into a one-entry response buffer per port.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : request/response handshakes for both ports
//   alu_op..alu_D     : ALU inputs, straight from the issue registers
//   alu_Y1, alu_Y2    : ALU results (combinational)
//   busy              : issue stage valid or any response pending
module alu_arbiter #(
    parameter int DATA_W     = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_arbiter_if.slave      bus,
    output logic [2:0]        alu_op,
    output logic              alu_form,
    output logic [1:0]        alu_vec,
    output logic [3:0]        alu_sel,
    output logic [DATA_W-1:0] alu_A,
    output logic [DATA_W-1:0] alu_B,
    output logic [DATA_W-1:0] alu_C,
    output logic [DATA_W-1:0] alu_D,
    input  logic [DATA_W-1:0] alu_Y1,
    input  logic [DATA_W-1:0] alu_Y2,
    output logic              busy
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b100,
        OP_COPY = 3'b111
    } op_e;

    function automatic logic op_supported(input logic [2:0] op);
        logic ok;
        case (op)
            OP_ADD, OP_SUB, OP_COPY: ok = 1'b1;
            default:                 ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Issue stage
    logic              iss_valid_q, iss_valid_d;
    logic              iss_port_q,  iss_port_d;
    logic [2:0]        iss_op_q,    iss_op_d;
    logic              iss_form_q,  iss_form_d;
    logic [1:0]        iss_vec_q,   iss_vec_d;
    logic [3:0]        iss_sel_q,   iss_sel_d;
    logic [DATA_W-1:0] iss_a_q, iss_a_d;
    logic [DATA_W-1:0] iss_b_q, iss_b_d;
    logic [DATA_W-1:0] iss_c_q, iss_c_d;
    logic [DATA_W-1:0] iss_d_q, iss_d_d;
    logic              last_grant_q, last_grant_d;

    // Response buffers
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [1:0]          rsp_err_q,   rsp_err_d;
    logic [2*DATA_W-1:0] rsp_y1_q,    rsp_y1_d;
    logic [2*DATA_W-1:0] rsp_y2_q,    rsp_y2_d;

    logic [1:0]          port_busy;
    logic [1:0]          eligible;
    logic [1:0]          grant;
    logic                gnt_port;
    logic [4*DATA_W-1:0] opnd_sel;
    logic                iss_ok;

    assign iss_ok = op_supported(iss_op_q);

    // Arbitration. A full response slot that is being drained this cycle
    // does not block its port, so a port can refill every other cycle.
    always_comb begin
        port_busy[0] = (iss_valid_q & ~iss_port_q) | (rsp_valid_q[0] & ~bus.rsp_ready[0]);
        port_busy[1] = (iss_valid_q &  iss_port_q) | (rsp_valid_q[1] & ~bus.rsp_ready[1]);
        eligible     = bus.req_valid & ~port_busy & {2{rst_n}};
        grant        = 2'b00;
        case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (FIXED_PRIO || last_grant_q) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        gnt_port = grant[1];
    end

    assign bus.req_ready = grant;

    // Issue-stage next state; descriptor registers hold when nothing is granted
    always_comb begin
        opnd_sel     = gnt_port ? bus.req_opnd[8*DATA_W-1:4*DATA_W]
                                : bus.req_opnd[4*DATA_W-1:0];
        iss_valid_d  = |grant;
        iss_port_d   = iss_port_q;
        iss_op_d     = iss_op_q;
        iss_form_d   = iss_form_q;
        iss_vec_d    = iss_vec_q;
        iss_sel_d    = iss_sel_q;
        iss_a_d      = iss_a_q;
        iss_b_d      = iss_b_q;
        iss_c_d      = iss_c_q;
        iss_d_d      = iss_d_q;
        last_grant_d = last_grant_q;
        if (|grant) begin
            iss_port_d   = gnt_port;
            iss_op_d     = gnt_port ? bus.req_op[5:3]   : bus.req_op[2:0];
            iss_form_d   = gnt_port ? bus.req_form[1]   : bus.req_form[0];
            iss_vec_d    = gnt_port ? bus.req_vec[3:2]  : bus.req_vec[1:0];
            iss_sel_d    = gnt_port ? bus.req_sel[7:4]  : bus.req_sel[3:0];
            iss_a_d      = opnd_sel[4*DATA_W-1:3*DATA_W];
            iss_b_d      = opnd_sel[3*DATA_W-1:2*DATA_W];
            iss_c_d      = opnd_sel[2*DATA_W-1:DATA_W];
            iss_d_d      = opnd_sel[DATA_W-1:0];
            last_grant_d = gnt_port;
        end
    end

    // Response next state: drain first, then a completing load overrides it
    always_comb begin
        rsp_valid_d = rsp_valid_q & ~bus.rsp_ready;
        rsp_err_d   = rsp_err_q;
        rsp_y1_d    = rsp_y1_q;
        rsp_y2_d    = rsp_y2_q;
        if (iss_valid_q) begin
            if (iss_port_q) begin
                rsp_valid_d[1]               = 1'b1;
                rsp_err_d[1]                 = ~iss_ok;
                rsp_y1_d[2*DATA_W-1:DATA_W]  = iss_ok ? alu_Y1 : '0;
                rsp_y2_d[2*DATA_W-1:DATA_W]  = iss_ok ? alu_Y2 : '0;
            end else begin
                rsp_valid_d[0]               = 1'b1;
                rsp_err_d[0]                 = ~iss_ok;
                rsp_y1_d[DATA_W-1:0]         = iss_ok ? alu_Y1 : '0;
                rsp_y2_d[DATA_W-1:0]         = iss_ok ? alu_Y2 : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_q  <= 1'b0;
            iss_port_q   <= 1'b0;
            iss_op_q     <= '0;
            iss_form_q   <= 1'b0;
            iss_vec_q    <= '0;
            iss_sel_q    <= '0;
            iss_a_q      <= '0;
            iss_b_q      <= '0;
            iss_c_q      <= '0;
            iss_d_q      <= '0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= '0;
            rsp_err_q    <= '0;
            rsp_y1_q     <= '0;
            rsp_y2_q     <= '0;
        end else begin
            iss_valid_q  <= iss_valid_d;
            iss_port_q   <= iss_port_d;
            iss_op_q     <= iss_op_d;
            iss_form_q   <= iss_form_d;
            iss_vec_q    <= iss_vec_d;
            iss_sel_q    <= iss_sel_d;
            iss_a_q      <= iss_a_d;
            iss_b_q      <= iss_b_d;
            iss_c_q      <= iss_c_d;
            iss_d_q      <= iss_d_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_y1_q     <= rsp_y1_d;
            rsp_y2_q     <= rsp_y2_d;
        end
    end

    // Unsupported opcodes are presented to the ALU as ADD
    assign alu_op   = iss_ok ? iss_op_q : OP_ADD;
    assign alu_form = iss_form_q;
    assign alu_vec  = iss_vec_q;
    assign alu_sel  = iss_sel_q;
    assign alu_A    = iss_a_q;
    assign alu_B    = iss_b_q;
    assign alu_C    = iss_c_q;
    assign alu_D    = iss_d_q;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_Y1    = rsp_y1_q;
    assign bus.rsp_Y2    = rsp_y2_q;

    assign busy = iss_valid_q | (|rsp_valid_q);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: drives two arbiters (round-robin and fixed priority) with
// identical stimulus and checks both against a transaction-level reference
// model of grant, issue and response-buffer behaviour.
module tb_alu_arbiter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Stimulus shared by both DUTs
    logic [1:0]   d_rv = '0;
    logic [5:0]   d_op = '0;
    logic [1:0]   d_form = '0;
    logic [3:0]   d_vec = '0;
    logic [7:0]   d_sel = '0;
    logic [255:0] d_opnd = '0;
    logic [1:0]   d_rr = 2'b11;

    alu_arbiter_if #(.DATA_W(W)) bus0 ();
    alu_arbiter_if #(.DATA_W(W)) bus1 ();

    assign bus0.req_valid = d_rv;   assign bus1.req_valid = d_rv;
    assign bus0.req_op    = d_op;   assign bus1.req_op    = d_op;
    assign bus0.req_form  = d_form; assign bus1.req_form  = d_form;
    assign bus0.req_vec   = d_vec;  assign bus1.req_vec   = d_vec;
    assign bus0.req_sel   = d_sel;  assign bus1.req_sel   = d_sel;
    assign bus0.req_opnd  = d_opnd; assign bus1.req_opnd  = d_opnd;
    assign bus0.rsp_ready = d_rr;   assign bus1.rsp_ready = d_rr;

    logic [2:0]  a_op [2];
    logic        a_form [2];
    logic [1:0]  a_vec [2];
    logic [3:0]  a_sel [2];
    logic [31:0] a_A [2], a_B [2], a_C [2], a_D [2], a_Y1 [2], a_Y2 [2];
    logic        a_busy [2];

    // Bench ALU: ADD Y1=A+C,Y2=B+D; SUB differences; COPY passes A,B;
    // anything else gives garbage so a leaked opcode is visible.
    function automatic logic [31:0] f_y1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] c);
        case (op)
            3'b000:  return a + c;
            3'b100:  return a - c;
            3'b111:  return a;
            default: return 32'hBAD0_0001 ^ a ^ c;
        endcase
    endfunction

    function automatic logic [31:0] f_y2(input logic [2:0] op, input logic [31:0] b, input logic [31:0] d);
        case (op)
            3'b000:  return b + d;
            3'b100:  return b - d;
            3'b111:  return b;
            default: return ~(b ^ d);
        endcase
    endfunction

    function automatic logic sup(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b100) || (op == 3'b111);
    endfunction

    assign a_Y1[0] = f_y1(a_op[0], a_A[0], a_C[0]);
    assign a_Y2[0] = f_y2(a_op[0], a_B[0], a_D[0]);
    assign a_Y1[1] = f_y1(a_op[1], a_A[1], a_C[1]);
    assign a_Y2[1] = f_y2(a_op[1], a_B[1], a_D[1]);

    alu_arbiter #(.DATA_W(W), .FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .alu_op(a_op[0]), .alu_form(a_form[0]), .alu_vec(a_vec[0]), .alu_sel(a_sel[0]),
        .alu_A(a_A[0]), .alu_B(a_B[0]), .alu_C(a_C[0]), .alu_D(a_D[0]),
        .alu_Y1(a_Y1[0]), .alu_Y2(a_Y2[0]), .busy(a_busy[0])
    );

    alu_arbiter #(.DATA_W(W), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .alu_op(a_op[1]), .alu_form(a_form[1]), .alu_vec(a_vec[1]), .alu_sel(a_sel[1]),
        .alu_A(a_A[1]), .alu_B(a_B[1]), .alu_C(a_C[1]), .alu_D(a_D[1]),
        .alu_Y1(a_Y1[1]), .alu_Y2(a_Y2[1]), .busy(a_busy[1])
    );

    logic [1:0]  o_rdy [2], o_rv [2], o_err [2];
    logic [63:0] o_y1 [2], o_y2 [2];
    assign o_rdy[0] = bus0.req_ready; assign o_rdy[1] = bus1.req_ready;
    assign o_rv[0]  = bus0.rsp_valid; assign o_rv[1]  = bus1.rsp_valid;
    assign o_err[0] = bus0.rsp_err;   assign o_err[1] = bus1.rsp_err;
    assign o_y1[0]  = bus0.rsp_Y1;    assign o_y1[1]  = bus1.rsp_Y1;
    assign o_y2[0]  = bus0.rsp_Y2;    assign o_y2[1]  = bus1.rsp_Y2;

    // Reference model, one per DUT (index 1 = fixed priority)
    logic         mv_iss [2];
    int           mv_port [2];
    logic [2:0]   mv_op [2];
    logic         mv_form [2];
    logic [1:0]   mv_vec [2];
    logic [3:0]   mv_sel [2];
    logic [127:0] mv_opnd [2];
    int           mv_last [2];
    logic [1:0]   mv_rv [2], mv_err [2];
    logic [63:0]  mv_y1 [2], mv_y2 [2];
    int           loads [2][2];
    int           hs [2][2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mv_iss[m] = 1'b0; mv_port[m] = 0; mv_op[m] = '0; mv_form[m] = 1'b0;
            mv_vec[m] = '0; mv_sel[m] = '0; mv_opnd[m] = '0; mv_last[m] = 1;
            mv_rv[m] = '0; mv_err[m] = '0; mv_y1[m] = '0; mv_y2[m] = '0;
        end
    endtask

    function automatic logic [1:0] exp_grant(input int m);
        logic [1:0] e;
        for (int p = 0; p < 2; p++)
            e[p] = d_rv[p] && !(mv_iss[m] && mv_port[m] == p) && !(mv_rv[m][p] && !d_rr[p]);
        if (e == 2'b11) return (m == 1 || mv_last[m] == 1) ? 2'b01 : 2'b10;
        return e;
    endfunction

    task automatic model_step(input int m);
        logic [1:0] g;
        int p;
        g = exp_grant(m);
        for (int q = 0; q < 2; q++)
            if (mv_rv[m][q] && d_rr[q]) mv_rv[m][q] = 1'b0;
        if (mv_iss[m]) begin
            p = mv_port[m];
            mv_rv[m][p]  = 1'b1;
            mv_err[m][p] = !sup(mv_op[m]);
            mv_y1[m][32*p +: 32] = sup(mv_op[m]) ? f_y1(mv_op[m], mv_opnd[m][127:96], mv_opnd[m][63:32]) : 32'h0;
            mv_y2[m][32*p +: 32] = sup(mv_op[m]) ? f_y2(mv_op[m], mv_opnd[m][95:64], mv_opnd[m][31:0])  : 32'h0;
            loads[m][p]++;
        end
        if (g != 2'b00) begin
            p = g[1] ? 1 : 0;
            mv_iss[m]  = 1'b1;
            mv_port[m] = p;
            mv_op[m]   = d_op[3*p +: 3];
            mv_form[m] = d_form[p];
            mv_vec[m]  = d_vec[2*p +: 2];
            mv_sel[m]  = d_sel[4*p +: 4];
            mv_opnd[m] = d_opnd[128*p +: 128];
            mv_last[m] = p;
        end else begin
            mv_iss[m] = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            logic [1:0] g;
            g = rst_n ? exp_grant(m) : 2'b00;
            chk($sformatf("m%0d_req_ready", m), o_rdy[m], g);
            chk($sformatf("m%0d_alu_op", m), a_op[m], sup(mv_op[m]) ? mv_op[m] : 3'b000);
            chk($sformatf("m%0d_alu_ctl", m), {a_form[m], a_vec[m], a_sel[m]},
                {mv_form[m], mv_vec[m], mv_sel[m]});
            chk($sformatf("m%0d_alu_AB", m), {a_A[m], a_B[m]}, mv_opnd[m][127:64]);
            chk($sformatf("m%0d_alu_CD", m), {a_C[m], a_D[m]}, mv_opnd[m][63:0]);
            chk($sformatf("m%0d_rsp_valid", m), o_rv[m], mv_rv[m]);
            chk($sformatf("m%0d_rsp_err", m), o_err[m], mv_err[m]);
            chk($sformatf("m%0d_rsp_Y1", m), o_y1[m], mv_y1[m]);
            chk($sformatf("m%0d_rsp_Y2", m), o_y2[m], mv_y2[m]);
            chk($sformatf("m%0d_busy", m), a_busy[m], mv_iss[m] | (|mv_rv[m]));
        end
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    task automatic tick();
        if (rst_n) begin
            for (int m = 0; m < 2; m++) begin
                for (int p = 0; p < 2; p++)
                    if (o_rv[m][p] && d_rr[p]) hs[m][p]++;
                model_step(m);
            end
        end else begin
            model_reset();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    logic [1:0] prev_fp;

    initial begin
        for (int m = 0; m < 2; m++)
            for (int p = 0; p < 2; p++) begin loads[m][p] = 0; hs[m][p] = 0; end
        model_reset();

        // Reset state
        settle();
        tick();
        tick();
        rst_n = 1'b1;

        // Single ADD on port 0: A=5 B=1 C=7 D=2
        d_rv = 2'b01; d_op = 6'b000_000;
        d_opnd[127:0] = {32'd5, 32'd1, 32'd7, 32'd2};
        settle();
        chk("t1_rdy0_c0", o_rdy[0][0], 1'b1);
        tick();
        d_rv = 2'b00;
        settle();
        chk("t1_aluA_c1", a_A[0], 32'd5);
        chk("t1_busy_c1", a_busy[0], 1'b1);
        tick();
        settle();
        chk("t1_rv0_c2", o_rv[0][0], 1'b1);
        chk("t1_y1", o_y1[0][31:0], 32'd12);
        chk("t1_y2", o_y2[0][31:0], 32'd3);
        chk("t1_err", o_err[0][0], 1'b0);
        chk("t1_busy_c2", a_busy[0], 1'b1);
        tick();

        // Both ports continuously requesting SUB: strict alternation
        d_rv = 2'b11; d_op = 6'b100_100;
        d_opnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        prev_fp = 2'b00;
        for (int i = 0; i < 10; i++) begin
            settle();
            if (i > 0) begin
                chk("t2_busy_rr", a_busy[0], 1'b1);
                chk("t2_fp_no_two_p1", prev_fp[1] & o_rdy[1][1], 1'b0);
            end
            prev_fp = o_rdy[1];
            tick();
        end
        d_rv = 2'b00;
        repeat (3) cyc();

        // Port 1 response blocked for 5 cycles
        d_rr = 2'b01; d_rv = 2'b10; d_op = 6'b100_000;
        d_opnd[255:128] = {32'd100, 32'd0, 32'd30, 32'd0};
        settle();
        chk("t3_rdy1_first", o_rdy[0][1], 1'b1);
        tick();
        cyc();
        d_opnd[255:128] = {32'd50, 32'd0, 32'd8, 32'd0};
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t3_blocked_rdy1", o_rdy[0][1], 1'b0);
            chk("t3_hold_y1", o_y1[0][63:32], 32'd70);
            tick();
        end
        d_rr = 2'b11;
        settle();
        chk("t3_refill_rdy1", o_rdy[0][1], 1'b1);
        tick();
        d_rv = 2'b00;
        settle();
        chk("t3_drained", o_rv[0][1], 1'b0);
        tick();
        settle();
        chk("t3_new_rv1", o_rv[0][1], 1'b1);
        chk("t3_new_y1", o_y1[0][63:32], 32'd42);
        tick();

        // Unsupported opcode on port 0, then ADD
        d_rv = 2'b01; d_op = 6'b000_001; d_opnd[127:0] = '1;
        cyc();
        d_rv = 2'b00;
        settle();
        chk("t4_alu_op_forced", a_op[0], 3'b000);
        chk("t4_alu_A", a_A[0], 32'hFFFF_FFFF);
        tick();
        settle();
        chk("t4_err", o_err[0][0], 1'b1);
        chk("t4_y1_zero", o_y1[0][31:0], 32'd0);
        chk("t4_y2_zero", o_y2[0][31:0], 32'd0);
        d_rv = 2'b01; d_op = 6'b000_000; d_opnd[127:0] = {32'd3, 32'd0, 32'd4, 32'd0};
        settle();
        chk("t4_refill_rdy0", o_rdy[0][0], 1'b1);
        tick();
        d_rv = 2'b00;
        cyc();
        settle();
        chk("t4_err_cleared", o_err[0][0], 1'b0);
        chk("t4_add_y1", o_y1[0][31:0], 32'd7);
        tick();

        // Asynchronous reset while a port-1 operation is in issue
        d_rv = 2'b10; d_op = 6'b000_000;
        cyc();
        d_rv = 2'b00;
        #2;
        rst_n = 1'b0;
        model_reset();
        settle();
        chk("t5_busy_rst", a_busy[0], 1'b0);
        chk("t5_aluA_rst", a_A[0], 32'd0);
        tick();
        rst_n = 1'b1;
        cyc();
        cyc();
        settle();
        chk("t5_no_rsp1", o_rv[0][1], 1'b0);
        d_rv = 2'b11;
        settle();
        chk("t5_first_contention", o_rdy[0], 2'b01);
        tick();
        d_rv = 2'b00;
        repeat (2) cyc();

        // Back-to-back port 0 requests with immediate drain
        d_rv = 2'b01; d_op = 6'b111_111;
        for (int i = 0; i < 6; i++) begin
            d_opnd[127:0] = {$urandom, $urandom, $urandom, $urandom};
            cyc();
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            d_rv = 2'($urandom);
            for (int p = 0; p < 2; p++) begin
                case ($urandom_range(0, 4))
                    0: d_op[3*p +: 3] = 3'b000;
                    1: d_op[3*p +: 3] = 3'b100;
                    2: d_op[3*p +: 3] = 3'b111;
                    default: d_op[3*p +: 3] = 3'($urandom);
                endcase
            end
            d_form = 2'($urandom);
            d_vec  = 4'($urandom);
            d_sel  = 8'($urandom);
            d_opnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            d_rr   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            cyc();
        end

        // Drain and check one handshake per loaded result
        d_rv = 2'b00; d_rr = 2'b11;
        repeat (4) cyc();
        for (int m = 0; m < 2; m++)
            for (int p = 0; p < 2; p++)
                chk($sformatf("m%0d_p%0d_handshakes", m, p), hs[m][p], loads[m][p]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
